// File: rtl/qdr_multi_arb.sv
// qdr_multi_arb: multi-channel QDR request arbiter with a priority channel,
// starvation guard, round-robin fallback and in-order read-return routing.
module qdr_multi_arb #(
    parameter int ADDR_WIDTH      = 22,
    parameter int DATA_WIDTH      = 36,
    parameter int BE_WIDTH        = 4,
    parameter int NUM_CH          = 2,
    parameter int MAX_OUTSTANDING = 16,
    parameter int PRIO_CH         = 0,
    parameter int STARVE_LIMIT    = 64
) (
    input  logic                           qdr_clk,
    input  logic                           qdr_rst,
    input  logic                           phy_rdy,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_CH-1:0]              req_wr,
    input  logic [NUM_CH-1:0]              req_rd,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   req_wr_data,
    input  logic [NUM_CH*BE_WIDTH-1:0]     req_wr_be,
    output logic [NUM_CH-1:0]              req_ack,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [NUM_CH-1:0]              rd_dvld,
    output logic [ADDR_WIDTH-1:0]          master_addr,
    output logic                           master_wr_strb,
    output logic [DATA_WIDTH-1:0]          master_wr_data,
    output logic [BE_WIDTH-1:0]            master_wr_be,
    output logic                           master_rd_strb,
    input  logic [DATA_WIDTH-1:0]          master_rd_data,
    input  logic                           master_rd_dvld,
    output logic                           tag_err
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int NW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [NW-1:0] CNT_MAX    = NW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [PW-1:0] PTR_LAST   = PW'(MAX_OUTSTANDING - 1);
    // Empty mask when PRIO_CH == NUM_CH: every channel is round-robin.
    localparam logic [NUM_CH-1:0] PRIO_MASK = NUM_CH'(1) << PRIO_CH;

    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] np_elig;
    logic [NUM_CH-1:0] grant;
    logic [CW-1:0]     gnt_idx;
    logic [CW-1:0]     rr_idx;
    logic [CW-1:0]     rr_ptr;
    logic              rr_found;
    logic              prio_win;
    logic              gnt_vld;
    logic              gnt_wr;
    logic              np_gnt;
    logic              rd_ok;
    logic              tag_push;
    logic              tag_pop;
    logic [SW-1:0]     starve;
    logic [NW-1:0]     tag_cnt;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     tag_mem [MAX_OUTSTANDING];
    int                j;

    assign rd_ok   = tag_cnt < CNT_MAX;
    assign elig    = {NUM_CH{phy_rdy}} & (req_wr | (req_rd & {NUM_CH{rd_ok}}));
    assign np_elig = elig & ~PRIO_MASK;

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        j        = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            j = (int'(rr_ptr) + k) % NUM_CH;
            if (!rr_found && np_elig[j]) begin
                rr_found = 1'b1;
                rr_idx   = CW'(j);
            end
        end
    end

    // Priority channel yields only once the others have waited long enough.
    assign prio_win = (|(elig & PRIO_MASK))
                    & ~((starve == STARVE_MAX) & (|np_elig));

    always_comb begin
        gnt_vld = ~qdr_rst & (prio_win | rr_found);
        gnt_idx = prio_win ? CW'(PRIO_CH) : rr_idx;
        grant   = gnt_vld ? (NUM_CH'(1) << gnt_idx) : '0;
        gnt_wr  = req_wr[gnt_idx];
    end

    assign req_ack  = grant;
    assign np_gnt   = |(grant & ~PRIO_MASK);
    assign tag_push = gnt_vld & ~gnt_wr;
    assign tag_pop  = master_rd_dvld & (tag_cnt != '0);

    always_ff @(posedge qdr_clk) begin
        if (tag_push) tag_mem[wr_ptr] <= gnt_idx;
    end

    always_ff @(posedge qdr_clk or posedge qdr_rst) begin
        if (qdr_rst) begin
            master_wr_strb <= 1'b0;
            master_rd_strb <= 1'b0;
            master_addr    <= '0;
            master_wr_data <= '0;
            master_wr_be   <= '0;
            rd_data        <= '0;
            rd_dvld        <= '0;
            tag_err        <= 1'b0;
            tag_cnt        <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            starve         <= '0;
            rr_ptr         <= '0;
        end else begin
            master_wr_strb <= gnt_vld & gnt_wr;
            master_rd_strb <= tag_push;
            if (gnt_vld) begin
                master_addr    <= req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                master_wr_data <= req_wr_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                master_wr_be   <= req_wr_be[int'(gnt_idx)*BE_WIDTH +: BE_WIDTH];
            end

            rd_data <= master_rd_data;
            rd_dvld <= tag_pop ? (NUM_CH'(1) << tag_mem[rd_ptr]) : '0;
            if (master_rd_dvld && tag_cnt == '0) tag_err <= 1'b1;

            if (tag_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (tag_pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            if (tag_push && !tag_pop) tag_cnt <= tag_cnt + 1'b1;
            else if (tag_pop && !tag_push) tag_cnt <= tag_cnt - 1'b1;

            if (np_gnt) begin
                starve <= '0;
                rr_ptr <= gnt_idx;
            end else if ((|np_elig) && starve != STARVE_MAX) begin
                starve <= starve + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qdr_multi_arb.sv
// Bench for qdr_multi_arb: directed scenarios then randomized traffic,
// all checked against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_qdr_multi_arb;

    localparam int AW = 22;
    localparam int DW = 36;
    localparam int BW = 4;
    localparam int NC = 2;
    localparam int MO = 16;
    localparam int SL = 4;
    localparam int RC = 3;

    logic qdr_clk = 1'b0;
    logic qdr_rst = 1'b0;
    logic phy_rdy = 1'b0;
    logic [NC*AW-1:0] req_addr = '0;
    logic [NC-1:0] req_wr = '0;
    logic [NC-1:0] req_rd = '0;
    logic [NC*DW-1:0] req_wr_data = '0;
    logic [NC*BW-1:0] req_wr_be = '0;
    logic [NC-1:0] req_ack;
    logic [DW-1:0] rd_data;
    logic [NC-1:0] rd_dvld;
    logic [AW-1:0] master_addr;
    logic master_wr_strb;
    logic [DW-1:0] master_wr_data;
    logic [BW-1:0] master_wr_be;
    logic master_rd_strb;
    logic [DW-1:0] master_rd_data = '0;
    logic master_rd_dvld = 1'b0;
    logic tag_err;

    // pure round-robin instance, writes only
    logic [RC*AW-1:0] rr_addr = '0;
    logic [RC-1:0] rr_wr = '0;
    logic [RC-1:0] rr_rd = '0;
    logic [RC*DW-1:0] rr_wdata = '0;
    logic [RC*BW-1:0] rr_wbe = '0;
    logic [RC-1:0] rr_ack;
    logic [DW-1:0] rr_rdata;
    logic [RC-1:0] rr_dvld;
    logic [AW-1:0] rr_maddr;
    logic rr_wstrb;
    logic [DW-1:0] rr_mwdata;
    logic [BW-1:0] rr_mbe;
    logic rr_rstrb;
    logic [DW-1:0] rr_mrdata = '0;
    logic rr_mdvld = 1'b0;
    logic rr_terr;

    qdr_multi_arb #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .NUM_CH(NC),
        .MAX_OUTSTANDING(MO), .PRIO_CH(0), .STARVE_LIMIT(SL)
    ) dut (
        .qdr_clk(qdr_clk), .qdr_rst(qdr_rst), .phy_rdy(phy_rdy),
        .req_addr(req_addr), .req_wr(req_wr), .req_rd(req_rd),
        .req_wr_data(req_wr_data), .req_wr_be(req_wr_be),
        .req_ack(req_ack), .rd_data(rd_data), .rd_dvld(rd_dvld),
        .master_addr(master_addr), .master_wr_strb(master_wr_strb),
        .master_wr_data(master_wr_data), .master_wr_be(master_wr_be),
        .master_rd_strb(master_rd_strb), .master_rd_data(master_rd_data),
        .master_rd_dvld(master_rd_dvld), .tag_err(tag_err)
    );

    qdr_multi_arb #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .NUM_CH(RC),
        .MAX_OUTSTANDING(MO), .PRIO_CH(RC), .STARVE_LIMIT(SL)
    ) dut_rr (
        .qdr_clk(qdr_clk), .qdr_rst(qdr_rst), .phy_rdy(phy_rdy),
        .req_addr(rr_addr), .req_wr(rr_wr), .req_rd(rr_rd),
        .req_wr_data(rr_wdata), .req_wr_be(rr_wbe),
        .req_ack(rr_ack), .rd_data(rr_rdata), .rd_dvld(rr_dvld),
        .master_addr(rr_maddr), .master_wr_strb(rr_wstrb),
        .master_wr_data(rr_mwdata), .master_wr_be(rr_mbe),
        .master_rd_strb(rr_rstrb), .master_rd_data(rr_mrdata),
        .master_rd_dvld(rr_mdvld), .tag_err(rr_terr)
    );

    always #5 qdr_clk = ~qdr_clk;

    int n_assert = 0;
    int n_fail = 0;

    // model state
    int tagq[$];
    int m_starve;
    int rr_last;
    logic m_terr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [BW-1:0] m_be;

    // last observed DUT values
    logic [NC-1:0] o_ack;
    logic [RC-1:0] o_rr_ack;
    logic o_wstrb, o_rstrb, o_terr;
    logic [NC-1:0] o_dvld;
    logic [DW-1:0] o_rdata;
    logic [AW-1:0] o_addr;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tagq.delete();
        m_starve = 0;
        rr_last = 0;
        m_terr = 1'b0;
        m_addr = '0;
        m_wdata = '0;
        m_be = '0;
    endtask

    // One clock: called just after a falling edge with inputs applied.
    task automatic cycle();
        logic [NC-1:0] el;
        logic [NC-1:0] e_ack;
        logic [NC-1:0] e_dvld;
        logic [RC-1:0] e_rr;
        logic e_w, e_r;
        logic [DW-1:0] e_rd;
        int g, rg, idx;
        #1;
        for (int i = 0; i < NC; i++)
            el[i] = phy_rdy && (req_wr[i] || (req_rd[i] && tagq.size() < MO));
        g = -1;
        if (el[0] && !(m_starve == SL && el[1])) g = 0;
        else if (el[1]) g = 1;
        e_ack = (g < 0) ? '0 : NC'(1) << g;
        o_ack = req_ack;
        chk("ack", o_ack, e_ack);

        rg = -1;
        if (phy_rdy)
            for (int k = 1; k <= RC; k++) begin
                idx = (rr_last + k) % RC;
                if (rg < 0 && rr_wr[idx]) rg = idx;
            end
        e_rr = (rg < 0) ? '0 : RC'(1) << rg;
        o_rr_ack = rr_ack;
        chk("rr_ack", o_rr_ack, e_rr);
        if (rg >= 0) rr_last = rg;

        e_w = (g >= 0) && req_wr[g];
        e_r = (g >= 0) && !req_wr[g];
        if (g >= 0) begin
            m_addr = req_addr[g*AW +: AW];
            m_wdata = req_wr_data[g*DW +: DW];
            m_be = req_wr_be[g*BW +: BW];
        end
        if (g == 1) m_starve = 0;
        else if (el[1] && m_starve < SL) m_starve++;
        e_dvld = '0;
        if (master_rd_dvld) begin
            if (tagq.size() > 0) e_dvld = NC'(1) << tagq.pop_front();
            else m_terr = 1'b1;
        end
        e_rd = master_rd_data;
        if (e_r) tagq.push_back(g);

        @(posedge qdr_clk);
        #1;
        o_wstrb = master_wr_strb;
        o_rstrb = master_rd_strb;
        o_dvld = rd_dvld;
        o_rdata = rd_data;
        o_terr = tag_err;
        o_addr = master_addr;
        chk("wr_strb", o_wstrb, e_w);
        chk("rd_strb", o_rstrb, e_r);
        chk("m_addr", o_addr, m_addr);
        chk("m_wdata", master_wr_data, m_wdata);
        chk("m_be", master_wr_be, m_be);
        chk("rd_dvld", o_dvld, e_dvld);
        chk("tag_err", o_terr, m_terr);
        if (e_dvld != '0) chk("rd_data", o_rdata, e_rd);
        chk("rr_wstrb", rr_wstrb, rg >= 0);

        @(negedge qdr_clk);
        if (e_w) req_wr[g] = 1'b0;
        if (e_r) req_rd[g] = 1'b0;
        if (rg >= 0) rr_wr[rg] = 1'b0;
        master_rd_dvld = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " ack"}, req_ack, 0);
        chk({tag, " rd_dvld"}, rd_dvld, 0);
        chk({tag, " wr_strb"}, master_wr_strb, 0);
        chk({tag, " rd_strb"}, master_rd_strb, 0);
        chk({tag, " tag_err"}, tag_err, 0);
        chk({tag, " addr"}, master_addr, 0);
        chk({tag, " wdata"}, master_wr_data, 0);
        chk({tag, " be"}, master_wr_be, 0);
        chk({tag, " rd_data"}, rd_data, 0);
    endtask

    task automatic pulse_reset();
        qdr_rst = 1'b1;
        #1;
        check_reset_outputs("reset");
        model_reset();
        @(negedge qdr_clk);
        qdr_rst = 1'b0;
    endtask

    task automatic randomize_data();
        req_addr = (NC*AW)'({$urandom(), $urandom()});
        req_wr_data = (NC*DW)'({$urandom(), $urandom(), $urandom()});
        req_wr_be = (NC*BW)'($urandom());
        master_rd_data = DW'({$urandom(), $urandom()});
        rr_addr = (RC*AW)'({$urandom(), $urandom(), $urandom()});
    endtask

    task automatic drain_tags();
        for (int i = 0; i < 40 && tagq.size() > 0; i++) begin
            randomize_data();
            master_rd_dvld = 1'b1;
            cycle();
        end
    endtask

    task automatic serve_requests();
        for (int i = 0; i < 20 && (req_wr | req_rd) != '0; i++) begin
            randomize_data();
            cycle();
        end
        chk("requests served", req_wr | req_rd, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacks, nrs;
        model_reset();
        #1 qdr_rst = 1'b1;
        #2;
        check_reset_outputs("async reset");
        repeat (2) @(negedge qdr_clk);
        check_reset_outputs("held reset");
        qdr_rst = 1'b0;
        phy_rdy = 1'b1;

        // ch1 single write
        randomize_data();
        req_addr[AW +: AW] = AW'('h100);
        req_wr[1] = 1'b1;
        cycle();
        chk("single wr ack", o_ack, 2'b10);
        chk("single wr strb", o_wstrb, 1);
        chk("single wr addr", o_addr, 'h100);

        // continuous requests, starvation release every 5th cycle
        for (int i = 0; i < 10; i++) begin
            randomize_data();
            req_wr = 2'b11;
            cycle();
            chk("starve pattern", o_ack, (i % 5 == 4) ? 2'b10 : 2'b01);
        end
        serve_requests();

        // 17 reads against a 16-deep tag FIFO
        nacks = 0;
        nrs = 0;
        for (int i = 0; i < 20; i++) begin
            randomize_data();
            req_rd[0] = 1'b1;
            cycle();
            if (o_ack[0]) nacks++;
            if (o_rstrb) nrs++;
        end
        chk("full acks", nacks, 16);
        chk("full rd strobes", nrs, 16);
        req_wr[1] = 1'b1;
        cycle();
        chk("write while full", o_ack, 2'b10);
        master_rd_dvld = 1'b1;
        cycle();
        chk("no ack on return cycle", o_ack, 0);
        cycle();
        chk("17th read ack", o_ack, 2'b01);
        drain_tags();

        // return routing in issue order
        req_rd[1] = 1'b1;
        cycle();
        req_rd[0] = 1'b1;
        cycle();
        master_rd_dvld = 1'b1;
        master_rd_data = DW'('hA);
        cycle();
        chk("route first dvld", o_dvld, 2'b10);
        chk("route first data", o_rdata, 'hA);
        master_rd_dvld = 1'b1;
        master_rd_data = DW'('hB);
        cycle();
        chk("route second dvld", o_dvld, 2'b01);
        chk("route second data", o_rdata, 'hB);

        // write before read on the same channel
        req_wr[0] = 1'b1;
        req_rd[0] = 1'b1;
        cycle();
        chk("wr first", o_wstrb, 1);
        cycle();
        chk("rd second", o_rstrb, 1);
        drain_tags();

        // phy not ready: no grants, returns still routed
        req_rd[1] = 1'b1;
        cycle();
        phy_rdy = 1'b0;
        req_wr = 2'b11;
        req_rd[0] = 1'b1;
        rr_wr = 3'b111;
        for (int i = 0; i < 3; i++) begin
            master_rd_dvld = (i == 1);
            master_rd_data = DW'('hC);
            cycle();
            chk("phy down ack", o_ack, 0);
            chk("phy down rr ack", o_rr_ack, 0);
            if (i == 1) chk("phy down dvld", o_dvld, 2'b10);
        end
        phy_rdy = 1'b1;
        serve_requests();
        drain_tags();
        for (int i = 0; i < 4 && rr_wr != '0; i++) cycle();

        // reset mid-operation discards tags
        req_rd = 2'b11;
        cycle();
        cycle();
        pulse_reset();
        master_rd_dvld = 1'b1;
        cycle();
        chk("stale return dvld", o_dvld, 0);
        chk("stale return tag_err", o_terr, 1);
        cycle();
        chk("tag_err sticky", o_terr, 1);
        pulse_reset();

        // pure round-robin ordering from reset
        for (int i = 0; i < 6; i++) begin
            rr_wr = 3'b111;
            cycle();
            chk("rr order", o_rr_ack, 3'b001 << ((i + 1) % 3));
        end
        rr_wr = '0;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            randomize_data();
            phy_rdy = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < NC; i++)
                if (!req_wr[i] && !req_rd[i]) begin
                    req_wr[i] = ($urandom_range(0, 2) == 0);
                    req_rd[i] = ($urandom_range(0, 1) == 0);
                end
            for (int i = 0; i < RC; i++)
                if (!rr_wr[i]) rr_wr[i] = ($urandom_range(0, 2) == 0);
            master_rd_dvld = ($urandom_range(0, 3) == 0) &&
                             (tagq.size() > 0 || $urandom_range(0, 30) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
